// File: rtl/countdown_timer_pkg.sv
// countdown_pkg: shared types and helpers for the countdown timer slice.
//   state_t : FSM states IDLE, RUN, PAUSE, EXPIRED
//   MIN_W   : width of the minutes field
//   SEC_W   : width of the seconds field
//   clamp   : saturates a preset field to an upper limit
// Optional feature macro used elsewhere: COUNTDOWN_AUTO_RELOAD_EN
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam int MIN_W = 7;
  localparam int SEC_W = 7;

  // MIN_W and SEC_W are equal, so one 7-bit clamp serves both fields.
  function automatic logic [MIN_W-1:0] clamp(input logic [MIN_W-1:0] value,
                                             input logic [MIN_W-1:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// countdown_timer_if: control/status bundle of the countdown timer.
//   tick, load, load_min, load_sec, start, stop : controller -> timer
//   minutes, seconds, running, expired, done    : timer -> controller
//   modport master : controller side (drives controls, reads status)
//   modport slave  : timer side
import countdown_pkg::*;

interface countdown_timer_if;
  logic             tick;
  logic             load;
  logic [MIN_W-1:0] load_min;
  logic [SEC_W-1:0] load_sec;
  logic             start;
  logic             stop;
  logic [MIN_W-1:0] minutes;
  logic [SEC_W-1:0] seconds;
  logic             running;
  logic             expired;
  logic             done;

  modport master (
    output tick, load, load_min, load_sec, start, stop,
    input  minutes, seconds, running, expired, done
  );

  modport slave (
    input  tick, load, load_min, load_sec, start, stop,
    output minutes, seconds, running, expired, done
  );
endinterface

// File: rtl/countdown_timer_mod_n_down_counter.sv
// mod_n_down_counter: loadable modulo-N down counter.
//   clk        : rising-edge clock
//   reset      : synchronous, active-low; clears the count
//   i_load     : load i_load_val (wins over i_en)
//   i_load_val : value to load
//   i_en       : decrement by one, wrapping 0 -> MODULUS-1
//   o_count    : current count
//   o_borrow   : count is zero, so the next enable wraps and borrows
import countdown_pkg::*;

module mod_n_down_counter #(
  parameter int WIDTH   = 7,
  parameter int MODULUS = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count,
  output logic             o_borrow
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= (r_count == '0) ? WIDTH'(MODULUS - 1) : r_count - WIDTH'(1);
    end
  end

  assign o_count  = r_count;
  assign o_borrow = (r_count == '0);

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: counts a loaded MM:SS preset down to 00:00 on each tick.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : countdown_timer_if.slave (tick/load/start/stop controls,
//           minutes/seconds/running/expired/done status)
// Macro COUNTDOWN_AUTO_RELOAD_EN: when defined, reaching 00:00 pulses done,
// reloads the preset on the same edge and keeps running; expired never rises.
import countdown_pkg::*;

module countdown_timer #(
  parameter int MAX_MIN     = 99,
  parameter int SEC_PER_MIN = 60
) (
  input  logic                clk,
  input  logic                reset,
  countdown_timer_if.slave    bus
);

  state_t           r_state;
  state_t           w_next_state;
  logic [MIN_W-1:0] r_preset_min;
  logic [SEC_W-1:0] r_preset_sec;
  logic             r_running;
  logic             r_expired;
  logic             r_done;

  logic [MIN_W-1:0] w_min;
  logic [SEC_W-1:0] w_sec;
  logic             w_min_zero;
  logic             w_sec_zero;
  logic             w_count_zero;
  logic             w_user_load;
  logic             w_dec;
  logic             w_hit_zero;
  logic             w_cnt_load;
  logic [MIN_W-1:0] w_clamp_min;
  logic [SEC_W-1:0] w_clamp_sec;
  logic [MIN_W-1:0] w_load_min;
  logic [SEC_W-1:0] w_load_sec;

  assign w_clamp_min  = clamp(bus.load_min, MIN_W'(MAX_MIN));
  assign w_clamp_sec  = clamp(bus.load_sec, SEC_W'(SEC_PER_MIN - 1));
  assign w_count_zero = w_min_zero && w_sec_zero;

  // Load is only honoured outside RUN; stop in RUN swallows a coincident tick.
  assign w_user_load = bus.load && (r_state != RUN);
  assign w_dec       = (r_state == RUN) && bus.tick && !bus.stop;

  // 00:00 is only ever reached from 00:01 because RUN leaves on arrival.
  assign w_hit_zero  = w_dec && w_min_zero && (w_sec == SEC_W'(1));

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  assign w_cnt_load  = w_user_load || w_hit_zero;
`else
  assign w_cnt_load  = w_user_load;
`endif

  // Outside a user load the only load source is the stored preset.
  assign w_load_min = w_user_load ? w_clamp_min : r_preset_min;
  assign w_load_sec = w_user_load ? w_clamp_sec : r_preset_sec;

  mod_n_down_counter #(.WIDTH(SEC_W), .MODULUS(SEC_PER_MIN)) u_sec (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_cnt_load),
    .i_load_val(w_load_sec),
    .i_en      (w_dec),
    .o_count   (w_sec),
    .o_borrow  (w_sec_zero)
  );

  // Minutes step only when seconds wrap from 0 to SEC_PER_MIN-1.
  mod_n_down_counter #(.WIDTH(MIN_W), .MODULUS(MAX_MIN + 1)) u_min (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_cnt_load),
    .i_load_val(w_load_min),
    .i_en      (w_dec && w_sec_zero),
    .o_count   (w_min),
    .o_borrow  (w_min_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_preset_min <= '0;
      r_preset_sec <= '0;
      r_running    <= 1'b0;
      r_expired    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_running <= (w_next_state == RUN);
      r_expired <= (w_next_state == EXPIRED);
      r_done    <= w_hit_zero;
      if (w_user_load) begin
        r_preset_min <= w_clamp_min;
        r_preset_sec <= w_clamp_sec;
      end
    end
  end

  // A load in IDLE/PAUSE masks a same-cycle start; start needs a non-zero count.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE, PAUSE: begin
        if (!bus.load && bus.start && !w_count_zero) w_next_state = RUN;
      end
      RUN: begin
        if (bus.stop) begin
          w_next_state = PAUSE;
        end else if (w_hit_zero) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          w_next_state = RUN;
`else
          w_next_state = EXPIRED;
`endif
        end
      end
      EXPIRED: begin
        if (bus.load) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign bus.minutes = w_min;
  assign bus.seconds = w_sec;
  assign bus.running = r_running;
  assign bus.expired = r_expired;
  assign bus.done    = r_done;

endmodule
